// File: rtl/matrix_pkg.sv
// Shared definitions for the 3x3 matrix multiplier drain path: sizes, FSM
// encoding and element-index to (row,col) lookup tables.
package matrix_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int N          = 3;
   localparam int ELEMS      = N * N;

   localparam logic [3:0] LAST_IDX = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // Two bits per element index, index 0 in the LSBs
   localparam logic [2*ELEMS-1:0] IDX_DIV_N = {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
   localparam logic [2*ELEMS-1:0] IDX_MOD_N = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

   localparam logic [2*ELEMS-1:0] RM_ROW_TAB = IDX_DIV_N;
   localparam logic [2*ELEMS-1:0] RM_COL_TAB = IDX_MOD_N;
   localparam logic [2*ELEMS-1:0] CM_ROW_TAB = IDX_MOD_N;
   localparam logic [2*ELEMS-1:0] CM_COL_TAB = IDX_DIV_N;

endpackage

// File: rtl/matrix_idx_map.sv
// Maps a stream element index to its (row,col) position and last flag for
// either row-major or column-major traversal of a 3x3 matrix.
module matrix_idx_map
   import matrix_pkg::*;
#(
   parameter bit COL_MAJOR = 1'b0
) (
   input  logic [3:0] idx,
   output logic [1:0] row,
   output logic [1:0] col,
   output logic       last
);

   logic [4:0] bit_pos;

   assign bit_pos = {idx, 1'b0};

   always_comb begin
      row  = 2'd0;
      col  = 2'd0;
      last = 1'b0;
      if (idx <= LAST_IDX) begin
         row  = COL_MAJOR ? CM_ROW_TAB[bit_pos +: 2] : RM_ROW_TAB[bit_pos +: 2];
         col  = COL_MAJOR ? CM_COL_TAB[bit_pos +: 2] : RM_COL_TAB[bit_pos +: 2];
         last = (idx == LAST_IDX);
      end
   end

endmodule

// File: rtl/matrix_result_reader.sv
// Snapshots the nine multiplier products on the done rising edge and streams
// them over a valid/ready port with row/col tags, then pulses rd_done.
//
// state | meaning
// IDLE  | waiting for a mat_done rising edge to capture results
// SEND  | presenting buffer[idx] on the output port
// FIN   | rd_done pulse after the ninth handshake
module matrix_result_reader
   import matrix_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter bit COL_MAJOR = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mat_done,
   input  logic [DATA_W-1:0] m1_in,
   input  logic [DATA_W-1:0] m2_in,
   input  logic [DATA_W-1:0] m3_in,
   input  logic [DATA_W-1:0] m4_in,
   input  logic [DATA_W-1:0] m5_in,
   input  logic [DATA_W-1:0] m6_in,
   input  logic [DATA_W-1:0] m7_in,
   input  logic [DATA_W-1:0] m8_in,
   input  logic [DATA_W-1:0] m9_in,
   input  logic              abort,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_row,
   output logic [1:0]        out_col,
   output logic              out_last,
   output logic              busy,
   output logic              rd_done,
   output logic              overrun
);

   state_t            state;
   logic [3:0]        idx;
   logic              done_d;
   logic [DATA_W-1:0] buf_q [ELEMS];

   logic       done_rise;
   logic       hs;
   logic [3:0] idx_nxt;
   logic [1:0] nxt_row;
   logic [1:0] nxt_col;
   logic       nxt_last;
   logic [3:0] nxt_sel;

   assign done_rise = mat_done & ~done_d;
   assign hs        = out_valid & out_ready;
   assign idx_nxt   = idx + 4'd1;
   assign busy      = (state != ST_IDLE);

   // Outputs are registered, so the map looks one element ahead
   matrix_idx_map #(.COL_MAJOR(COL_MAJOR)) u_idx_map (
      .idx  (idx_nxt),
      .row  (nxt_row),
      .col  (nxt_col),
      .last (nxt_last)
   );

   assign nxt_sel = {2'b00, nxt_row} * 4'd3 + {2'b00, nxt_col};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         idx       <= 4'd0;
         done_d    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= 2'd0;
         out_col   <= 2'd0;
         out_last  <= 1'b0;
         rd_done   <= 1'b0;
         overrun   <= 1'b0;
         for (int i = 0; i < ELEMS; i++) buf_q[i] <= '0;
      end else begin
         done_d  <= mat_done;
         rd_done <= 1'b0;
         if (abort) begin
            state     <= ST_IDLE;
            idx       <= 4'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
         end else begin
            if (done_rise && state != ST_IDLE) overrun <= 1'b1;
            case (state)
               ST_IDLE: begin
                  if (done_rise) begin
                     buf_q[0]  <= m1_in;
                     buf_q[1]  <= m2_in;
                     buf_q[2]  <= m3_in;
                     buf_q[3]  <= m4_in;
                     buf_q[4]  <= m5_in;
                     buf_q[5]  <= m6_in;
                     buf_q[6]  <= m7_in;
                     buf_q[7]  <= m8_in;
                     buf_q[8]  <= m9_in;
                     idx       <= 4'd0;
                     out_valid <= 1'b1;
                     out_data  <= m1_in;
                     out_row   <= 2'd0;
                     out_col   <= 2'd0;
                     out_last  <= 1'b0;
                     state     <= ST_SEND;
                  end
               end
               ST_SEND: begin
                  if (hs) begin
                     if (idx == LAST_IDX) begin
                        idx       <= 4'd0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        rd_done   <= 1'b1;
                        state     <= ST_FIN;
                     end else begin
                        idx      <= idx_nxt;
                        out_data <= buf_q[nxt_sel];
                        out_row  <= nxt_row;
                        out_col  <= nxt_col;
                        out_last <= nxt_last;
                     end
                  end
               end
               ST_FIN:  state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/matrix_result_reader.md
Name: matrix_result_reader

Overview:
- Drain side of the 3x3 systolic matrix multiplier.
- On the multiplier's done rising edge, snapshots the nine 8-bit products C00..C22.
- Streams them one element per valid/ready handshake, in row-major or column-major order, with row/col tags and a last flag.
- Pulses rd_done after the final element so the controller can reset the multiplier for the next operation.

Parameters:
- DATA_W, 8, width of each result element.
- COL_MAJOR, 0, 0 = row-major stream order (C00,C01,C02,C10,...); 1 = column-major (C00,C10,C20,C01,...).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); clears all state immediately.
- mat_done  in  1  multiplier done level; stays high until the multiplier is reset.
- m1_in..m9_in  in  DATA_W each  multiplier results; m1..m3 = C00..C02, m4..m6 = C10..C12, m7..m9 = C20..C22.
- abort  in  1  synchronous; cancels the stream.
- out_valid  out  1  element available.
- out_ready  in  1  consumer accepts the element.
- out_data  out  DATA_W  current element.
- out_row  out  2  row index 0..2 of out_data.
- out_col  out  2  column index 0..2 of out_data.
- out_last  out  1  high with the ninth element.
- busy  out  1  state != IDLE.
- rd_done  out  1  one-cycle pulse after the ninth handshake.
- overrun  out  1  sticky: a new mat_done edge arrived while busy.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, rd_done=0, overrun=0, state=IDLE, idx=0, done_d=0, all nine buffer registers=0.
- Edge detect: done_rise = mat_done & ~done_d; done_d <= mat_done every cycle.
  - done_d resets to 0, so mat_done already high at reset release yields exactly one capture.
- States:
  - IDLE: when done_rise, load all nine m*_in into the buffer, set idx=0, go to SEND.
  - SEND: out_valid=1. out_data/out_row/out_col come from the buffer entry selected by idx and COL_MAJOR.
    - Handshake (out_valid & out_ready): idx+1.
    - On the handshake at idx=8, go to FIN, idx=0.
  - FIN: rd_done=1 for exactly this cycle, out_valid=0, go to IDLE.
- Latency:
  - Edge k samples done_rise. out_valid is high after edge k, so the first element is visible one cycle after mat_done rises.
  - With out_ready held 1, nine consecutive cycles of valid. rd_done follows on the cycle after the ninth.
  - A new capture is possible from the cycle after FIN.
- Handshake rules:
  - While out_valid & ~out_ready, out_data/out_row/out_col/out_last are held stable.
  - out_valid never drops without a handshake, except on abort or reset.
  - out_valid does not depend combinationally on out_ready.
- Index mapping:
  - Row-major: row=idx/3, col=idx%3.
  - Column-major: col=idx/3, row=idx%3.
  - Buffer element = C[row][col]. out_last = (idx==8).
- Buffer is frozen during SEND/FIN; m*_in changes are ignored.
- Overrun:
  - done_rise while in SEND or FIN sets overrun=1. The buffer is not reloaded and the stream continues unaffected.
  - overrun is cleared only by reset or abort.
- Abort:
  - In any state, next state = IDLE, out_valid=0, idx=0, overrun=0, no rd_done.
  - Abort wins over a simultaneous handshake (that element is not counted) and over a simultaneous done_rise (no capture).
- Reset mid-stream: all outputs return to reset values asynchronously. The stream does not resume.
- Data is passed through unmodified; no arithmetic on elements.

Decomposition:
- Shared package (matrix_pkg):
  - DATA_W default.
  - Matrix dimension constant N=3 and ELEMS=9.
  - State encoding IDLE/SEND/FIN.
  - Element-index-to-(row,col) constants for both orders.
- One natural sub-module, matrix_idx_map: combinational idx + COL_MAJOR -> row, col, last. Reusable by a future input-side loader.

Test Plan:
- Basic row-major: results C=1..9 (m1=1..m9=9), pulse mat_done high, out_ready=1 -> out_data 1,2,...,9 on 9 consecutive cycles; row/col (0,0)..(2,2); out_last only with 9; rd_done one cycle later; busy low after.
- Column-major (COL_MAJOR=1), same inputs -> order 1,4,7,2,5,8,3,6,9 with (row,col) = (0,0),(1,0),(2,0),(0,1),...; out_last with 9.
- Backpressure: out_ready toggles 1,0,0,1,... -> each element held stable while ready=0; exactly 9 handshakes; m*_in changed to 0xFF mid-stream never appear on out_data.
- Overrun: drop and re-raise mat_done at element 4 -> overrun=1, stream completes with the original values; overrun stays 1 after rd_done; abort clears it.
- Abort collision: assert abort in the same cycle as the 5th handshake -> out_valid=0 next cycle, no rd_done, busy=0; next mat_done rise restarts from element C00.
- Async reset: assert reset low between clock edges mid-stream -> out_valid/busy drop immediately. With mat_done held high across reset release, one capture occurs and exactly one full stream follows.
